// File: rtl/ftdi_frame_parser.sv
// ftdi_frame_parser
//
// Consumer stage that sits directly behind the FTDI interface's receive FIFO.
// It pops raw bytes from that FIFO, which is a standard FIFO: data appears one
// cycle after the pop. It hunts for a sync byte and then parses frames of the
// form [SYNC][LEN][PAYLOAD x LEN][CHK]. Payload bytes are streamed to the core
// over a valid/ready handshake as they arrive. Every completed or aborted frame
// is answered by pushing a single ACK or NAK byte into the transmit FIFO.
//
// The checksum is the 8-bit sum of LEN and all payload bytes. The payload has
// already been streamed by the time the checksum is known, so the core must
// drop the frame's payload when it sees frame_err.
//
// Ports:
//   clk_pll    in   system clock; all logic runs on its rising edge
//   reset_n    in   asynchronous active-low reset
//   rx_data    in   [7:0] receive FIFO dout (valid the cycle after rx_pop)
//   rx_empty   in   receive FIFO empty
//   rx_pop     out  receive FIFO rd_en
//   tx_data    out  [7:0] transmit FIFO din (ACK_BYTE / NAK_BYTE)
//   tx_push    out  transmit FIFO wr_en
//   tx_full    in   transmit FIFO full
//   pl_data    out  [7:0] payload byte
//   pl_valid   out  payload byte valid
//   pl_last    out  final payload byte of the frame
//   pl_ready   in   core accepts the payload byte
//   frame_ok   out  one-cycle pulse, checksum matched
//   frame_err  out  one-cycle pulse, frame rejected
//   err_code   out  [1:0] reject cause (1 bad LEN, 2 bad CHK, 3 timeout),
//                   held until the next frame_err
module ftdi_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic       clk_pll,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_pop,
  output logic [7:0] tx_data,
  output logic       tx_push,
  input  logic       tx_full,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  output logic       pl_last,
  input  logic       pl_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             rd_pend;
  logic [7:0]       sum_q;
  logic [7:0]       remain_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             resp_nak;

  logic             capture;
  logic             in_frame;
  logic             len_bad;
  logic             pl_stall;
  logic             tmo_count_en;
  logic             tmo_hit;
  logic             ok_d;
  logic             err_d;
  logic [1:0]       code_d;

  // A pop issued last cycle means rx_data holds a fresh byte this cycle.
  // The state never changes between a pop and its capture: captures and
  // timeouts are mutually exclusive, and RESP never pops.
  assign capture  = rd_pend;
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign len_bad  = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);

  // A held payload byte that the core refuses is back-pressure, not
  // starvation, so those cycles never advance the timeout.
  assign pl_stall     = pl_valid && !pl_ready;
  assign tmo_count_en = in_frame && rx_empty && !rd_pend && !pl_stall;
  assign tmo_hit      = tmo_count_en && (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the decision for the frame result pulses. A frame
  // leaves through RESP exactly once, carrying either ok or err.
  always_comb begin
    state_d = state_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (capture && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (capture) begin
          if (len_bad) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = ST_RESP;
        end
      end
      ST_PAYLOAD: begin
        if (capture) begin
          if (remain_q == 8'd1) begin
            state_d = ST_CHK;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = ST_RESP;
        end
      end
      ST_CHK: begin
        if (capture) begin
          if (rx_data == sum_q) begin
            ok_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 2'd2;
          end
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!tx_full) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO-facing outputs. Only one read is ever outstanding, and in PAYLOAD we
  // only pop when the output register will be free by the time the byte
  // lands. Gating with reset_n keeps rx_pop low while reset is held.
  always_comb begin
    rx_pop  = 1'b0;
    tx_push = 1'b0;
    tx_data = 8'h00;
    if (reset_n && !rx_empty && !rd_pend && (state_q != ST_RESP) &&
        ((state_q != ST_PAYLOAD) || !pl_valid || pl_ready)) begin
      rx_pop = 1'b1;
    end
    if (state_q == ST_RESP) begin
      tx_data = resp_nak ? NAK_BYTE : ACK_BYTE;
      tx_push = !tx_full;
    end
  end

  // Read-pending flag, running checksum and remaining payload count.
  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      sum_q    <= 8'h00;
      remain_q <= 8'h00;
    end else begin
      rd_pend <= rx_pop;
      if (capture) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              sum_q <= 8'h00;
            end
          end
          ST_LEN: begin
            if (!len_bad) begin
              sum_q    <= rx_data;
              remain_q <= rx_data;
            end
          end
          ST_PAYLOAD: begin
            sum_q    <= sum_q + rx_data;
            remain_q <= remain_q - 8'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Starvation counter: restarts on every captured byte and whenever we are
  // outside a frame, so it only measures silence inside a frame.
  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (capture || !in_frame) begin
      tmo_cnt <= '0;
    end else if (tmo_count_en) begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  // Payload output register. A byte captured on the same cycle the core
  // accepts the previous one simply replaces it, keeping pl_valid high.
  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      pl_valid <= 1'b0;
      pl_data  <= 8'h00;
      pl_last  <= 1'b0;
    end else if (capture && (state_q == ST_PAYLOAD)) begin
      pl_valid <= 1'b1;
      pl_data  <= rx_data;
      pl_last  <= (remain_q == 8'd1);
    end else if (pl_valid && pl_ready) begin
      pl_valid <= 1'b0;
      pl_last  <= 1'b0;
    end
  end

  // Result pulses, sticky error cause and the response byte selection.
  always_ff @(posedge clk_pll or negedge reset_n) begin
    if (!reset_n) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      resp_nak  <= 1'b0;
    end else begin
      frame_ok  <= ok_d;
      frame_err <= err_d;
      if (err_d) begin
        err_code <= code_d;
      end
      if (ok_d || err_d) begin
        resp_nak <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_ftdi_frame_parser.sv
// tb_ftdi_frame_parser
//
// Bench for ftdi_frame_parser. A small non-FWFT FIFO model feeds the DUT.
// Expected payload, response bytes and frame results are worked out directly
// from how each frame was built: legal length, sum of LEN plus payload mod 256,
// and whether the checksum was deliberately corrupted. A negedge monitor
// collects what the DUT actually produced. Directed phases are followed by a
// randomized run with random back-pressure on both the payload and transmit
// sides.
module tb_ftdi_frame_parser;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXL = 64;
  localparam int         TMO  = 200;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  logic       clk_pll = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data = 8'h00;
  logic       rx_empty;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       tx_full;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_last;
  logic       pl_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  ftdi_frame_parser #(
    .SYNC_BYTE      (SYNC),
    .MAX_LEN        (MAXL),
    .TIMEOUT_CYCLES (TMO),
    .ACK_BYTE       (ACK),
    .NAK_BYTE       (NAK)
  ) dut (
    .clk_pll   (clk_pll),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .rx_pop    (rx_pop),
    .tx_data   (tx_data),
    .tx_push   (tx_push),
    .tx_full   (tx_full),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_last   (pl_last),
    .pl_ready  (pl_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  always #5 clk_pll = ~clk_pll;

  int cyc = 0;
  always @(posedge clk_pll) cyc <= cyc + 1;

  // Receive FIFO model: a ring buffer. Data shows up on rx_data one clock
  // after the pop, as with a standard (non first-word-fall-through) FIFO.
  logic [7:0] fifoMem [0:8191];
  int wrPtr = 0;
  int rdPtr = 0;
  int popUnderflow = 0;
  assign rx_empty = (wrPtr == rdPtr);

  always @(posedge clk_pll) begin
    if (rx_pop) begin
      if (wrPtr == rdPtr) begin
        popUnderflow <= popUnderflow + 1;
      end else begin
        rx_data <= fifoMem[rdPtr % 8192];
        rdPtr   <= rdPtr + 1;
      end
    end
  end

  // Observed traffic, and what the frames we built should produce.
  // Payload entries are {last, data}. Event entries are 0 for frame_ok or the
  // err_code for frame_err.
  logic [8:0] obsPl[$];
  logic [8:0] expPl[$];
  logic [7:0] obsTx[$];
  logic [7:0] expTx[$];
  logic [1:0] obsEv[$];
  logic [1:0] expEv[$];
  int bothPulse = 0;

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk_pll) begin
    if (reset_n) begin
      if (pl_valid && pl_ready) obsPl.push_back({pl_last, pl_data});
      if (tx_push) obsTx.push_back(tx_data);
      if (frame_ok) obsEv.push_back(2'd0);
      if (frame_err) obsEv.push_back(err_code);
      if (frame_ok && frame_err) bothPulse <= bothPulse + 1;
    end
  end

  int checks = 0;
  int fails  = 0;

  // Single checking task: every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {8'h00, rx_pop, tx_push, tx_data, pl_valid, pl_last, pl_data, frame_ok, frame_err, err_code};
  endfunction

  task automatic pushByte(input logic [7:0] b);
    fifoMem[wrPtr % 8192] = b;
    wrPtr++;
  endtask

  // Payload bytes for the next frame are staged here by the caller.
  logic [7:0] frameBuf [0:255];

  // Sends one frame built from frameBuf and records its expected results.
  // An illegal length sends only SYNC and LEN, since the parser gives up on
  // LEN. A nonzero chkDelta corrupts the checksum byte.
  task automatic applyStimulus(input logic [7:0] len, input logic [7:0] chkDelta);
    int sum;
    pushByte(SYNC);
    pushByte(len);
    if ((len == 8'd0) || (int'(len) > MAXL)) begin
      expEv.push_back(2'd1);
      expTx.push_back(NAK);
      return;
    end
    sum = int'(len);
    for (int i = 0; i < int'(len); i++) begin
      pushByte(frameBuf[i]);
      sum = sum + int'(frameBuf[i]);
      expPl.push_back({(i == int'(len) - 1), frameBuf[i]});
    end
    pushByte(8'(sum % 256) + chkDelta);
    if (chkDelta == 8'd0) begin
      expEv.push_back(2'd0);
      expTx.push_back(ACK);
    end else begin
      expEv.push_back(2'd2);
      expTx.push_back(NAK);
    end
  endtask

  // Waits until the FIFO is drained and every expected response was pushed.
  task automatic waitDrain(input string phase, input int budget);
    int n;
    n = 0;
    while (!((rdPtr == wrPtr) && (obsTx.size() == expTx.size())) && (n < budget)) begin
      @(negedge clk_pll);
      n++;
    end
    repeat (6) @(negedge clk_pll);
    checkOutput({phase, " responses drained"}, 32'(obsTx.size()), 32'(expTx.size()));
  endtask

  task automatic compareQueues(input string phase);
    checkOutput({phase, " payload count"}, 32'(obsPl.size()), 32'(expPl.size()));
    for (int i = 0; i < expPl.size(); i++) begin
      if (i < obsPl.size()) checkOutput($sformatf("%s payload[%0d]", phase, i), 32'(obsPl[i]), 32'(expPl[i]));
    end
    checkOutput({phase, " response count"}, 32'(obsTx.size()), 32'(expTx.size()));
    for (int i = 0; i < expTx.size(); i++) begin
      if (i < obsTx.size()) checkOutput($sformatf("%s response[%0d]", phase, i), 32'(obsTx[i]), 32'(expTx[i]));
    end
    checkOutput({phase, " result count"}, 32'(obsEv.size()), 32'(expEv.size()));
    for (int i = 0; i < expEv.size(); i++) begin
      if (i < obsEv.size()) checkOutput($sformatf("%s result[%0d]", phase, i), 32'(obsEv[i]), 32'(expEv[i]));
    end
    obsPl.delete();
    expPl.delete();
    obsTx.delete();
    expTx.delete();
    obsEv.delete();
    expEv.delete();
  endtask

  // Last-resort guard so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int tStart;
    int r;
    logic [7:0] len;
    logic [7:0] chkDelta;
    logic [7:0] b;

    reset_n  = 1'b0;
    pl_ready = 1'b1;
    tx_full  = 1'b0;
    repeat (3) @(negedge clk_pll);
    checkOutput("reset outputs", allOutputs(), 32'h0);
    @(posedge clk_pll);
    #1 reset_n = 1'b1;

    // Good frame at full rate.
    @(negedge clk_pll);
    frameBuf[0] = 8'h11;
    frameBuf[1] = 8'h22;
    frameBuf[2] = 8'h33;
    applyStimulus(8'd3, 8'd0);
    waitDrain("good frame", 300);
    compareQueues("good frame");

    // Same frame with a corrupted checksum.
    @(negedge clk_pll);
    applyStimulus(8'd3, 8'd7);
    waitDrain("bad chk", 300);
    compareQueues("bad chk");

    // Noise before sync, zero length, then one past the largest length.
    @(negedge clk_pll);
    pushByte(8'h00);
    pushByte(8'hFF);
    pushByte(8'h5A);
    applyStimulus(8'd0, 8'd0);
    applyStimulus(8'(MAXL + 1), 8'd0);
    waitDrain("bad len", 300);
    compareQueues("bad len");

    // Starvation mid-payload: the error must land exactly TMO cycles after
    // the captured byte first appears on the payload port.
    @(negedge clk_pll);
    pushByte(SYNC);
    pushByte(8'h02);
    pushByte(8'h10);
    expPl.push_back({1'b0, 8'h10});
    expEv.push_back(2'd3);
    expTx.push_back(NAK);
    n = 0;
    while (!pl_valid && (n < 100)) begin
      @(negedge clk_pll);
      n++;
    end
    tStart = cyc;
    n = 0;
    while (!frame_err && (n < TMO + 50)) begin
      @(negedge clk_pll);
      n++;
    end
    checkOutput("timeout latency", 32'(cyc - tStart), 32'(TMO));
    waitDrain("timeout", 300);
    compareQueues("timeout");

    // Payload back-pressure for 20 cycles in the middle of a frame.
    @(negedge clk_pll);
    for (int i = 0; i < 5; i++) frameBuf[i] = 8'($urandom);
    applyStimulus(8'd5, 8'd0);
    n = 0;
    while (!pl_valid && (n < 100)) begin
      @(negedge clk_pll);
      n++;
    end
    @(posedge clk_pll);
    #1 pl_ready = 1'b0;
    repeat (20) begin
      @(negedge clk_pll);
      if (pl_valid) checkOutput("stall rx_pop", 32'(rx_pop), 32'h0);
      checkOutput("stall frame_err", 32'(frame_err), 32'h0);
    end
    @(posedge clk_pll);
    #1 pl_ready = 1'b1;
    waitDrain("stall", 300);
    compareQueues("stall");

    // Transmit FIFO full at the response: no push and no pop until it clears.
    @(posedge clk_pll);
    #1 tx_full = 1'b1;
    @(negedge clk_pll);
    frameBuf[0] = 8'($urandom);
    frameBuf[1] = 8'($urandom);
    applyStimulus(8'd2, 8'd0);
    pushByte(8'h00);
    n = 0;
    while (!frame_ok && (n < 300)) begin
      @(negedge clk_pll);
      n++;
    end
    repeat (10) begin
      @(negedge clk_pll);
      checkOutput("tx_full push", 32'(tx_push), 32'h0);
      checkOutput("tx_full pop", 32'(rx_pop), 32'h0);
    end
    @(posedge clk_pll);
    #1 tx_full = 1'b0;
    @(negedge clk_pll);
    checkOutput("ack on tx_full release", 32'({tx_push, tx_data}), 32'({1'b1, ACK}));
    waitDrain("tx_full", 300);
    compareQueues("tx_full");

    // Reset while a payload byte is held: everything clears at once and the
    // partial frame gets no response.
    @(posedge clk_pll);
    #1 pl_ready = 1'b0;
    @(negedge clk_pll);
    pushByte(SYNC);
    pushByte(8'h04);
    pushByte(8'h01);
    n = 0;
    while (!pl_valid && (n < 100)) begin
      @(negedge clk_pll);
      n++;
    end
    repeat (5) @(negedge clk_pll);
    checkOutput("held before reset", 32'({pl_valid, pl_data}), 32'({1'b1, 8'h01}));
    @(posedge clk_pll);
    #2 reset_n = 1'b0;
    #1 checkOutput("reset mid-frame", allOutputs(), 32'h0);
    @(posedge clk_pll);
    #1 reset_n = 1'b1;
    pl_ready = 1'b1;
    @(negedge clk_pll);
    for (int i = 0; i < 4; i++) frameBuf[i] = 8'($urandom);
    applyStimulus(8'd4, 8'd0);
    waitDrain("after reset", 300);
    compareQueues("after reset");

    // Randomized frames with noise, bad lengths, bad checksums and random
    // back-pressure on both sides.
    @(negedge clk_pll);
    for (int f = 0; f < 25; f++) begin
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        pushByte(b);
      end
      r = $urandom_range(0, 9);
      if (r == 0) len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255));
      else len = 8'($urandom_range(1, MAXL));
      chkDelta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      for (int i = 0; i < 256; i++) frameBuf[i] = 8'($urandom);
      applyStimulus(len, chkDelta);
    end
    n = 0;
    while (!((rdPtr == wrPtr) && (obsTx.size() == expTx.size())) && (n < 20000)) begin
      @(posedge clk_pll);
      #1;
      pl_ready = ($urandom_range(0, 3) != 0);
      tx_full  = ($urandom_range(0, 5) == 0);
      n++;
    end
    @(posedge clk_pll);
    #1;
    pl_ready = 1'b1;
    tx_full  = 1'b0;
    waitDrain("random", 300);
    compareQueues("random");

    checkOutput("no pop when empty", 32'(popUnderflow), 32'h0);
    checkOutput("ok/err exclusive", 32'(bothPulse), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
